// File: rtl/ls161_pkg.sv
// rtl/ls161_pkg.sv - shared state encoding and counter width for the LS161 divider controller
package ls161_pkg;

    localparam int DIV_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRELOAD = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

endpackage

// File: rtl/ls161_div_ctrl.sv
// rtl/ls161_div_ctrl.sv - drives an external 4-bit '161 counter as a divide-by-N tick generator
// Optional burst mode (BURST_LEN port, tick counter, DONE) under LS161_DIV_CTRL_BURST_EN.
module ls161_div_ctrl
    import ls161_pkg::*;
#(
    parameter int BURST_W = 8
) (
    input  logic               CLK,
    input  logic               CLR_n,
    input  logic               START,
    input  logic               STOP,
    input  logic [DIV_W-1:0]   DIV_M1,
`ifdef LS161_DIV_CTRL_BURST_EN
    input  logic [BURST_W-1:0] BURST_LEN,
`endif
    input  logic               RCO_IN,
    output logic [DIV_W-1:0]   D_OUT,
    output logic               LOAD_n_OUT,
    output logic               ENP_OUT,
    output logic               ENT_OUT,
    output logic               TICK,
    output logic               BUSY,
    output logic               DONE
);

    if (BURST_W < 1) begin : g_bad_burst_w
        $error("BURST_W must be at least 1");
    end

    state_t           state;
    logic [DIV_W-1:0] div_reg;
    logic             tick_q;
    logic             tick_hit;

`ifdef LS161_DIV_CTRL_BURST_EN
    logic [BURST_W-1:0] burst_reg;
    logic [BURST_W-1:0] tick_cnt;
    logic [BURST_W-1:0] tick_cnt_nxt;
    logic               done_q;

    assign tick_cnt_nxt = tick_cnt + 1'b1;
`endif

    assign tick_hit = (state == ST_RUN) && RCO_IN;

    always_ff @(posedge CLK) begin
        if (!CLR_n) begin
            state   <= ST_IDLE;
            div_reg <= '0;
            tick_q  <= 1'b0;
`ifdef LS161_DIV_CTRL_BURST_EN
            burst_reg <= '0;
            tick_cnt  <= '0;
            done_q    <= 1'b0;
`endif
        end else begin
            tick_q <= tick_hit;
`ifdef LS161_DIV_CTRL_BURST_EN
            done_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (START && !STOP) begin
                        div_reg <= DIV_M1;
`ifdef LS161_DIV_CTRL_BURST_EN
                        burst_reg <= BURST_LEN;
                        tick_cnt  <= '0;
`endif
                        state <= ST_PRELOAD;
                    end
                end
                ST_PRELOAD: begin
                    state <= STOP ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (STOP) begin
                        state <= ST_IDLE;
                    end else if (RCO_IN) begin
`ifdef LS161_DIV_CTRL_BURST_EN
                        // Leave on the terminal-count edge; the counter still reloads on it.
                        tick_cnt <= tick_cnt_nxt;
                        if ((burst_reg != '0) && (tick_cnt_nxt == burst_reg)) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Counter counts up from 15-DIV_M1 to 15, so LOAD on RCO gives a period of DIV_M1+1.
    always_comb begin
        D_OUT      = '0;
        LOAD_n_OUT = 1'b1;
        ENP_OUT    = 1'b0;
        ENT_OUT    = 1'b0;
        case (state)
            ST_PRELOAD: begin
                D_OUT      = ~div_reg;
                LOAD_n_OUT = 1'b0;
            end
            ST_RUN: begin
                D_OUT      = ~div_reg;
                LOAD_n_OUT = ~RCO_IN;
                ENP_OUT    = 1'b1;
                ENT_OUT    = 1'b1;
            end
            default: begin
                D_OUT      = '0;
                LOAD_n_OUT = 1'b1;
            end
        endcase
    end

    assign TICK = tick_q;
    assign BUSY = (state == ST_PRELOAD) || (state == ST_RUN);

`ifdef LS161_DIV_CTRL_BURST_EN
    assign DONE = done_q;
`else
    assign DONE = 1'b0;
`endif

endmodule

// File: tb/tb_ls161_div_ctrl.sv
// tb/tb_ls161_div_ctrl.sv - directed self-checking bench with a behavioural '161 counter attached
module tb_ls161_div_ctrl;

    logic       CLK = 1'b0;
    logic       CLR_n, START, STOP, RCO_IN;
    logic [3:0] DIV_M1;
    logic [7:0] BURST_LEN;
    logic [3:0] D_OUT;
    logic       LOAD_n_OUT, ENP_OUT, ENT_OUT, TICK, BUSY, DONE;
    logic [3:0] q;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    ls161_div_ctrl #(.BURST_W(8)) dut (
        .CLK(CLK), .CLR_n(CLR_n), .START(START), .STOP(STOP), .DIV_M1(DIV_M1),
`ifdef LS161_DIV_CTRL_BURST_EN
        .BURST_LEN(BURST_LEN),
`endif
        .RCO_IN(RCO_IN), .D_OUT(D_OUT), .LOAD_n_OUT(LOAD_n_OUT), .ENP_OUT(ENP_OUT),
        .ENT_OUT(ENT_OUT), .TICK(TICK), .BUSY(BUSY), .DONE(DONE)
    );

    // '161 model: synchronous load has priority over count, RCO gated by ENT
    assign RCO_IN = ENT_OUT && (q == 4'hF);
    always @(posedge CLK) begin
        if (!CLR_n)           q <= 4'h0;
        else if (!LOAD_n_OUT) q <= D_OUT;
        else if (ENP_OUT && ENT_OUT) q <= q + 4'h1;
    end

    typedef struct {
        logic       start, stop;
        logic [3:0] div;
        logic       busy, load_n;
        logic [3:0] d;
        logic       en, tick;
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mk(logic st, logic sp, logic [3:0] dv, logic b, logic ln,
                                logic [3:0] d, logic en, logic tk);
        vec_t v;
        v.start = st; v.stop = sp; v.div = dv; v.busy = b; v.load_n = ln;
        v.d = d; v.en = en; v.tick = tk;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic stop_run();
        STOP = 1'b1;
        cyc();
        STOP = 1'b0;
    endtask

    int tk[$];
    int dn[$];
    int busy_low;

    initial begin
        CLR_n = 1'b0; START = 1'b0; STOP = 1'b0; DIV_M1 = 4'd0; BURST_LEN = 8'd0;
        cyc(); cyc();
        chk("rst_busy", BUSY, 0);
        chk("rst_load_n", LOAD_n_OUT, 1);
        chk("rst_d", D_OUT, 0);
        chk("rst_enp", ENP_OUT, 0);
        chk("rst_tick", TICK, 0);
        chk("rst_done", DONE, 0);
        CLR_n = 1'b1;

        // N=3 run, cycle by cycle, aborted by STOP
        tbl[0] = mk(1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 4'd13, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd13, 1'b1, 1'b0);
        tbl[2] = mk(1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd13, 1'b1, 1'b0);
        tbl[3] = mk(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 4'd13, 1'b1, 1'b0);
        tbl[4] = mk(1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd13, 1'b1, 1'b1);
        tbl[5] = mk(1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd13, 1'b1, 1'b0);
        tbl[6] = mk(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 4'd13, 1'b1, 1'b0);
        tbl[7] = mk(1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd13, 1'b1, 1'b1);
        tbl[8] = mk(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            START = tbl[i].start; STOP = tbl[i].stop; DIV_M1 = tbl[i].div;
            cyc();
            chk($sformatf("v%0d_busy", i),   BUSY,       tbl[i].busy);
            chk($sformatf("v%0d_load_n", i), LOAD_n_OUT, tbl[i].load_n);
            chk($sformatf("v%0d_d", i),      D_OUT,      tbl[i].d);
            chk($sformatf("v%0d_en", i),     ENP_OUT & ENT_OUT, tbl[i].en);
            chk($sformatf("v%0d_tick", i),   TICK,       tbl[i].tick);
            chk($sformatf("v%0d_done", i),   DONE,       0);
        end
        START = 1'b0; STOP = 1'b0;

        // N=10 free-run: first TICK 11 cycles after PRELOAD, then every 10
        DIV_M1 = 4'd9; START = 1'b1;
        cyc();
        START = 1'b0;
        chk("n10_d", D_OUT, 6);
        tk.delete(); dn.delete();
        for (int n = 1; n <= 45; n++) begin
            cyc();
            if (TICK) tk.push_back(n);
            if (DONE) dn.push_back(n);
        end
        chk("n10_nticks", tk.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("n10_tick%0d", k), (tk.size() > k) ? tk[k] : -1, 11 + 10 * k);
        chk("n10_no_done", dn.size(), 0);
        stop_run();
        chk("n10_stop_busy", BUSY, 0);

        // N=1: reload every RUN cycle, TICK continuous from the second RUN cycle
        DIV_M1 = 4'd0; START = 1'b1;
        cyc();
        START = 1'b0;
        chk("n1_d", D_OUT, 15);
        chk("n1_pre_load_n", LOAD_n_OUT, 0);
        cyc();
        chk("n1_run1_load_n", LOAD_n_OUT, 0);
        chk("n1_run1_tick", TICK, 0);
        for (int n = 2; n <= 6; n++) begin
            cyc();
            chk($sformatf("n1_run%0d_load_n", n), LOAD_n_OUT, 0);
            chk($sformatf("n1_run%0d_tick", n), TICK, 1);
        end
        stop_run();

        // STOP with START held mid-run; STOP+START in IDLE stays IDLE
        DIV_M1 = 4'd3; START = 1'b1;
        cyc(); cyc(); cyc();
        chk("stp_run_busy", BUSY, 1);
        chk("stp_run_en", ENP_OUT, 1);
        STOP = 1'b1;
        cyc();
        chk("stp_idle_busy", BUSY, 0);
        chk("stp_tick", TICK, 0);
        chk("stp_done", DONE, 0);
        cyc();
        chk("stp_both_busy", BUSY, 0);
        STOP = 1'b0;
        cyc();
        chk("stp_restart_busy", BUSY, 1);
        chk("stp_restart_load_n", LOAD_n_OUT, 0);
        START = 1'b0;
        stop_run();

        // DIV_M1 change mid-run is ignored: period stays 16
        DIV_M1 = 4'd15; START = 1'b1;
        cyc();
        START = 1'b0; DIV_M1 = 4'd2;
        tk.delete();
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (TICK) tk.push_back(n);
        end
        chk("chg_nticks", tk.size(), 2);
        chk("chg_tick0", (tk.size() > 0) ? tk[0] : -1, 17);
        chk("chg_tick1", (tk.size() > 1) ? tk[1] : -1, 33);
        chk("chg_d", D_OUT, 0);

        // Two-edge reset in the middle of RUN
        CLR_n = 1'b0;
        cyc(); cyc();
        chk("mrst_busy", BUSY, 0);
        chk("mrst_load_n", LOAD_n_OUT, 1);
        chk("mrst_d", D_OUT, 0);
        chk("mrst_ent", ENT_OUT, 0);
        chk("mrst_tick", TICK, 0);
        chk("mrst_done", DONE, 0);
        CLR_n = 1'b1;
        START = 1'b1;
        cyc();
        START = 1'b0;
        chk("new_start_d", D_OUT, 13);
        stop_run();

`ifdef LS161_DIV_CTRL_BURST_EN
        // Burst of 5 at N=4: ticks 4 apart, DONE with the fifth, BUSY already low
        DIV_M1 = 4'd3; BURST_LEN = 8'd5; START = 1'b1;
        cyc();
        START = 1'b0; BURST_LEN = 8'd0;
        tk.delete(); dn.delete(); busy_low = -1;
        for (int n = 1; n <= 30; n++) begin
            cyc();
            if (TICK) tk.push_back(n);
            if (DONE) dn.push_back(n);
            if (!BUSY && busy_low < 0) busy_low = n;
        end
        chk("bst_nticks", tk.size(), 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("bst_tick%0d", k), (tk.size() > k) ? tk[k] : -1, 5 + 4 * k);
        chk("bst_ndone", dn.size(), 1);
        chk("bst_done_at", (dn.size() > 0) ? dn[0] : -1, 21);
        chk("bst_busy_low", busy_low, 21);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ls161_div_ctrl.md
LS161_DIV_CTRL -- requirements
Module: ls161_div_ctrl

Interface
REQ-001 SHALL have parameter: BURST_W, 8, width of burst-length port and tick counter.
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: CLR_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: START  input  1  begin divide run (sampled only in IDLE).
REQ-005 SHALL have port: STOP  input  1  abort run.
REQ-006 SHALL have port: DIV_M1  input  4  divide ratio minus one (N = DIV_M1+1, range 1..16).
REQ-007 SHALL have port: BURST_LEN  input  BURST_W  ticks per run, 0 = free-run (present only with macro, see REQ-027).
REQ-008 SHALL have port: RCO_IN  input  1  ripple-carry from the downstream 4-bit counter.
REQ-009 SHALL have port: D_OUT  output  4  counter parallel-load value.
REQ-010 SHALL have port: LOAD_n_OUT  output  1  counter load enable, active-low.
REQ-011 SHALL have port: ENP_OUT / ENT_OUT  output  1 each  counter enables.
REQ-012 SHALL have port: TICK  output  1  one-cycle pulse per completed divide period.
REQ-013 SHALL have ports: BUSY  output  1  high outside IDLE; DONE  output  1  one-cycle pulse at burst end.

Function
REQ-014 SHALL implement FSM states IDLE, PRELOAD, RUN.
REQ-015 SHALL, in IDLE with START=1 at an edge, latch DIV_M1 (and BURST_LEN) into internal registers, clear tick counter, go to PRELOAD.
REQ-016 SHALL, in PRELOAD: LOAD_n_OUT=0, ENP_OUT=ENT_OUT=0, D_OUT=~div_reg (= 15-DIV_M1); next edge -> RUN unconditionally (unless STOP/reset).
REQ-017 SHALL, in RUN: ENP_OUT=ENT_OUT=1, D_OUT=~div_reg, LOAD_n_OUT = ~RCO_IN combinationally, so counter reloads on the terminal-count edge; period exactly N cycles.
REQ-018 SHALL, in IDLE: LOAD_n_OUT=1, ENP_OUT=ENT_OUT=0, D_OUT=0.
REQ-019 SHALL register TICK = (state==RUN & RCO_IN); TICK lags RCO_IN by one cycle.
REQ-020 SHALL support N=1 (DIV_M1=0): D_OUT=15, RCO_IN high every RUN cycle, TICK high continuously from second RUN cycle.
REQ-021 SHALL ignore START while BUSY=1; DIV_M1/BURST_LEN changes during a run have no effect until the next START.
REQ-022 SHALL, on STOP=1 in PRELOAD or RUN, go to IDLE at that edge; no DONE; STOP has priority over RCO_IN; STOP in IDLE ignored; STOP and START together in IDLE -> stay IDLE.
REQ-023 SHALL assert BUSY combinationally from state (PRELOAD or RUN).

Reset
REQ-024 SHALL, when CLR_n=0 at an edge, force IDLE, clear div_reg, burst_reg, tick counter, TICK=0, DONE=0, regardless of state (mid-run reset aborts without DONE).
REQ-025 SHALL give reset output values: D_OUT=0, LOAD_n_OUT=1, ENP_OUT=ENT_OUT=0, TICK=0, BUSY=0, DONE=0.

Configuration
REQ-026 SHALL use macro LS161_DIV_CTRL_BURST_EN.
REQ-027 SHALL, with macro defined: count RUN&RCO_IN events; when count reaches burst_reg (non-zero), go to IDLE at that same edge (counter reload still occurs) and pulse DONE next cycle coincident with final TICK; burst_reg=0 free-runs until STOP.
REQ-028 SHALL, without macro: omit BURST_LEN port and tick counter, always free-run, DONE tied 0.

Structure
REQ-029 SHALL place FSM state enum and constant DIV_W=4 in shared package ls161_pkg.
REQ-030 SHALL be a single module; tick counter is inline (no sub-module).

Verification
REQ-031 Reset: CLR_n=0 for 2 edges mid-RUN -> all outputs at REQ-025 values next cycle, BUSY=0.
REQ-032 DIV_M1=9, free-run, counter model attached -> D_OUT=6, TICK every 10 cycles, first TICK 11 cycles after PRELOAD.
REQ-033 DIV_M1=0 -> D_OUT=15, LOAD_n_OUT=0 every RUN cycle, TICK continuous.
REQ-034 Burst (macro on): DIV_M1=3, BURST_LEN=5 -> exactly 5 TICKs 4 cycles apart, DONE pulse with 5th TICK, BUSY drops.
REQ-035 STOP asserted 2 cycles into RUN with START held -> IDLE next edge, no TICK, no DONE, START ignored until IDLE then accepted.
REQ-036 DIV_M1 changed 15->2 mid-run -> period stays 16 until next START.
